// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg -- shared loader/receiver state encodings and 8N1 constants      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_LO = 3'd1,
        LD_LEN_HI = 3'd2,
        LD_DATA   = 3'd3,
        LD_WRITE  = 3'd4,
        LD_CHECK  = 3'd5,
        LD_DONE   = 3'd6,
        LD_ERROR  = 3'd7
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned STOP_BITS        = 1;
    localparam int unsigned DEF_CLKS_PER_BIT = 434;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +--------------------------------------------------------------------------+
// | uart_rx_core -- 8N1 serial receiver with mid-bit sampling                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    logic            meta_q, sync_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // A start needs a high-to-low edge, so a low line left by a bad stop bit cannot retrigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign rx_byte    = shift_q;
    assign frame_err  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_mem_loader.sv
// +--------------------------------------------------------------------------+
// | uart_mem_loader -- serial program-image loader driving a memory write bus |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_mem_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int unsigned MAX_WORDS    = 1024,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Rx,
    output logic [15:0] address,
    output logic [31:0] w_data,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    logic       byte_valid, frame_err;
    logic [7:0] rx_byte;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (Rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    loader_state_t state_q, state_d;
    logic [15:0]   address_q, address_d;
    logic [31:0]   w_data_q, w_data_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d, hold_q, hold_d;
    logic [7:0]    chk_q, chk_d, len_lo_q, len_lo_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   remain_q, remain_d;
    logic [15:0]   len_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LD_IDLE;
            address_q <= BASE_ADDR;
            w_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b0;
            chk_q     <= '0;
            len_lo_q  <= '0;
            idx_q     <= '0;
            remain_q  <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            w_data_q  <= w_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            hold_q    <= hold_d;
            chk_q     <= chk_d;
            len_lo_q  <= len_lo_d;
            idx_q     <= idx_d;
            remain_q  <= remain_d;
        end
    end

    assign len_w = {rx_byte, len_lo_q};

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        w_data_d  = w_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        hold_d    = hold_q;
        chk_d     = chk_q;
        len_lo_d  = len_lo_q;
        idx_d     = idx_q;
        remain_d  = remain_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    hold_d    = 1'b1;
                    address_d = BASE_ADDR;
                    chk_d     = '0;
                    idx_d     = '0;
                    state_d   = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (byte_valid) begin
                    len_lo_d = rx_byte;
                    state_d  = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (byte_valid) begin
                    remain_d = len_w;
                    if (len_w == 16'd0) begin
                        state_d = LD_CHECK;
                    end else if (32'(len_w) > MAX_WORDS) begin
                        state_d = LD_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (byte_valid) begin
                    w_data_d[{idx_q, 3'b000} +: 8] = rx_byte;
                    chk_d = chk_q ^ rx_byte;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 2'd3) state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                address_d = address_q + 16'd4;
                remain_d  = remain_q - 16'd1;
                state_d   = (remain_q == 16'd1) ? LD_CHECK : LD_DATA;
            end
            LD_CHECK: begin
                if (byte_valid) begin
                    busy_d = 1'b0;
                    hold_d = 1'b0;
                    if (rx_byte == chk_q) begin
                        done_d  = 1'b1;
                        state_d = LD_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = LD_ERROR;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
        // A broken serial frame anywhere inside a load aborts it; completed writes stay.
        if (frame_err && state_q inside {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_WRITE, LD_CHECK}) begin
            state_d = LD_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
        end
    end

    assign address  = address_q;
    assign w_data   = w_data_q;
    assign we       = (state_q == LD_WRITE);
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cpu_hold = hold_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
// +--------------------------------------------------------------------------+
// | tb_uart_mem_loader -- randomized self-checking bench for uart_mem_loader  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_mem_loader;

    localparam int          CPB  = 4;
    localparam logic [15:0] BASE = 16'h0100;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Rx = 1'b1;
    logic [15:0] address;
    logic [31:0] w_data;
    logic        we, busy, done, error, cpu_hold;

    int checks = 0;
    int failures = 0;

    logic [15:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Rx       (Rx),
        .address  (address),
        .w_data   (w_data),
        .we       (we),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always @(negedge clk) begin
        if (we) begin
            obs_addr.push_back(address);
            obs_data.push_back(w_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            Rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        Rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic clear_writes();
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            check_eq({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            check_eq({tag, "_data"}, obs_data[i], exp_data[i]);
        end
    endtask

    task automatic expect_status(input string tag, input logic e_done, input logic e_err);
        check_eq({tag, "_done"}, done, e_done);
        check_eq({tag, "_error"}, error, e_err);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_hold"}, cpu_hold, 1'b0);
    endtask

    // Reference: words pack little-endian at BASE+4i; success iff CHK equals XOR of data bytes.
    task automatic run_frame(input string tag, input bq_t d, input logic [7:0] chk);
        int          n;
        logic [7:0]  x;
        n = d.size() / 4;
        x = 8'h00;
        clear_writes();
        foreach (d[i]) x ^= d[i];
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(BASE + 16'(4 * i));
            exp_data.push_back({d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
        end
        send_byte(8'hA5);
        check_eq({tag, "_hold_on"}, cpu_hold, 1'b1);
        check_eq({tag, "_busy_on"}, busy, 1'b1);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        foreach (d[i]) send_byte(d[i]);
        check_eq({tag, "_hold_pre_chk"}, cpu_hold, 1'b1);
        send_byte(chk);
        compare_writes(tag);
        expect_status(tag, x == chk, x != chk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t d;
        logic [7:0] x, c;
        int n;

        repeat (3) @(negedge clk);
        check_eq("rst_addr", address, BASE);
        check_eq("rst_wdata", w_data, 32'h0);
        check_eq("rst_we", we, 1'b0);
        expect_status("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // XOR of these eight bytes is 0x44.
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame("two_word_good", d, 8'h44);
        run_frame("two_word_chk00", d, 8'h00);
        run_frame("two_word_chk01", d, 8'h01);

        send_byte(8'h3C);
        send_byte(8'h5A);
        check_eq("junk_busy", busy, 1'b0);
        check_eq("junk_error_kept", error, 1'b1);
        d = {};
        run_frame("zero_len", d, 8'h00);

        // Bad stop bit in the middle of a word.
        clear_writes();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        check_eq("ferr_hold_before", cpu_hold, 1'b1);
        send_byte(8'h33, 1'b0);
        compare_writes("ferr");
        expect_status("ferr", 1'b0, 1'b1);

        // One-cycle low glitch on an idle line.
        @(negedge clk); Rx = 1'b0; @(negedge clk); Rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check_eq("glitch_busy", busy, 1'b0);
        check_eq("glitch_we_none", obs_addr.size(), 0);

        clear_writes();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
        compare_writes("oversize");
        expect_status("oversize", 1'b0, 1'b1);

        // Asynchronous reset mid-frame.
        clear_writes();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check_eq("arst_addr", address, BASE);
        check_eq("arst_wdata", w_data, 32'h0);
        check_eq("arst_we", we, 1'b0);
        expect_status("arst", 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        compare_writes("arst");
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("post_rst", d, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 3);
            d = {};
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                d.push_back(8'($urandom));
                x ^= d[i];
            end
            c = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'(($urandom_range(1, 255))));
            run_frame($sformatf("rand%0d", it), d, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
